multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the processor datapath. Fetches a 32-bit instruction, decodes it, and drives the shared 3-bit-opcode ALU, register file and data memory over a fixed FETCH/DECODE/EXEC/MEM/WB state machine. It owns the PC and applies the ALU `change_pc` result for `beq`/`blt`. It sits between the instruction/data memory ports and the register file plus ALU.

---
 rtl/multicycle_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; define MULTICYCLE_CTRL_PERF_EN for perf counters
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [2:0]  rf_raddr0,
    output logic [2:0]  rf_raddr1,
    input  logic [31:0] rf_rdata0,
    input  logic [31:0] rf_rdata1,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] alu_ip_0,
    output logic [31:0] alu_ip_1,
    output logic [2:0]  alu_opcode,
    input  logic [31:0] alu_op_0,
    input  logic        alu_change_pc,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] pc,
    output logic        busy,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc_q, pc_nx;
    logic [31:0] ir, ir_nx;
    logic [31:0] a_q, a_nx, b_q, b_nx, r_q, r_nx;

    logic [2:0]  op, rd, rs1, rs2;
    logic [31:0] imm_sx;
    logic        is_mem, is_br, is_st;
    logic        unused_ir_bits;

    assign op     = ir[31:29];
    assign rd     = ir[28:26];
    assign rs1    = ir[25:23];
    assign rs2    = ir[22:20];
    assign imm_sx = {{16{ir[15]}}, ir[15:0]};
    assign is_mem = (op[2:1] == 2'b00);
    assign is_br  = (op[2:1] == 2'b01);
    assign is_st  = (op == 3'd1);
    assign unused_ir_bits = &{1'b0, ir[19:16]};

    assign pc   = pc_q;
    assign busy = (state != S_IDLE);

    // State, PC and datapath latches; reset wins over any pending update
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc_q  <= RESET_PC;
            ir    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            ir    <= ir_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
            r_q   <= r_nx;
        end
    end

    // Next state, latch updates and all port drives for the current state
    always_comb begin
        state_nx   = state;
        pc_nx      = pc_q;
        ir_nx      = ir;
        a_nx       = a_q;
        b_nx       = b_q;
        r_nx       = r_q;
        imem_req   = 1'b0;
        imem_addr  = '0;
        rf_raddr0  = '0;
        rf_raddr1  = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        alu_ip_0   = '0;
        alu_ip_1   = '0;
        alu_opcode = '0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (run) state_nx = S_FETCH;
            end
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (imem_ready) begin
                    ir_nx    = imem_rdata;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                rf_raddr0 = rs1;
                rf_raddr1 = rs2;
                a_nx      = rf_rdata0;
                b_nx      = rf_rdata1;
                state_nx  = S_EXEC;
            end
            S_EXEC: begin
                alu_ip_0 = a_q;
                if (is_mem) begin
                    alu_opcode = 3'd4;
                    alu_ip_1   = imm_sx;
                    r_nx       = alu_op_0;
                    state_nx   = S_MEM;
                end else begin
                    alu_opcode = op;
                    alu_ip_1   = b_q;
                    if (is_br) begin
                        pc_nx    = alu_change_pc ? (pc_q + (imm_sx << 2)) : (pc_q + 32'd4);
                        state_nx = run ? S_FETCH : S_IDLE;
                    end else begin
                        r_nx     = alu_op_0;
                        state_nx = S_WB;
                    end
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_addr = r_q;
                if (is_st) begin
                    dmem_we    = 1'b1;
                    dmem_wdata = b_q;
                end
                if (dmem_ready) begin
                    if (is_st) begin
                        pc_nx    = pc_q + 32'd4;
                        state_nx = run ? S_FETCH : S_IDLE;
                    end else begin
                        r_nx     = dmem_rdata;
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = (rd != 3'd0);
                rf_waddr = rd;
                rf_wdata = r_q;
                pc_nx    = pc_q + 32'd4;
                state_nx = run ? S_FETCH : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // A reset cycle must not leave a request or a write visible to the memories or regfile
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic        retire;
    logic [31:0] cycle_q, retire_q;

    assign retire = ((state == S_EXEC) && is_br) ||
                    ((state == S_MEM) && is_st && dmem_ready) ||
                    (state == S_WB);

    // Busy-cycle and retired-instruction counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            if (busy)   cycle_q  <= cycle_q + 32'd1;
            if (retire) retire_q <= retire_q + 32'd1;
        end
    end

    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against an instruction-level model
module tb_multicycle_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        imem_req, imem_ready = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [2:0]  rf_raddr0, rf_raddr1, rf_waddr;
    logic [31:0] rf_rdata0, rf_rdata1, rf_wdata;
    logic        rf_we;
    logic [31:0] alu_ip_0, alu_ip_1, alu_op_0;
    logic [2:0]  alu_opcode;
    logic        alu_change_pc;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [31:0] pc, cycle_cnt, retire_cnt;
    logic        busy;

    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_ip_0(alu_ip_0), .alu_ip_1(alu_ip_1), .alu_opcode(alu_opcode),
        .alu_op_0(alu_op_0), .alu_change_pc(alu_change_pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .pc(pc), .busy(busy), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    // External ALU and combinational register file seen by the DUT
    logic [31:0] rf [8];
    assign rf_rdata0 = rf[rf_raddr0];
    assign rf_rdata1 = rf[rf_raddr1];

    always_comb begin
        alu_op_0      = '0;
        alu_change_pc = 1'b0;
        case (alu_opcode)
            3'd2: alu_change_pc = (alu_ip_0 == alu_ip_1);
            3'd3: alu_change_pc = (alu_ip_0 < alu_ip_1);
            3'd4: alu_op_0 = alu_ip_0 + alu_ip_1;
            3'd5: alu_op_0 = alu_ip_0 - alu_ip_1;
            3'd6: alu_op_0 = alu_ip_0 & alu_ip_1;
            3'd7: alu_op_0 = alu_ip_0 | alu_ip_1;
            default: ;
        endcase
    end

    // One record per clock: inputs to drive and outputs the DUT must show
    typedef struct packed {
        logic        rst, run, imem_ready, dmem_ready;
        logic [31:0] imem_rdata, dmem_rdata;
        logic        chk, zero, retire, busy, imem_req, dec, rf_we, dmem_req, dmem_we;
        logic [31:0] imem_addr;
        logic [2:0]  raddr0, raddr1, waddr, alu_opc;
        logic [31:0] wdata, ip0, ip1, dmem_addr, dmem_wdata, pc;
    } rec_t;

    rec_t        rq[$];
    logic [34:0] ini_q[$];
    logic [63:0] exp_st[$], st_log[$];
    logic [31:0] m_rf [8];
    logic [31:0] m_pc, m_cyc, m_ret;
    int          n_err = 0, n_chk = 0;
    int          cyc = 0, req_rise = 0, we_cyc = 0, addr_hold = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dmem_val(input logic [31:0] ad);
        return ad ^ 32'h5A5A_0000;
    endfunction

    function automatic rec_t base(input bit last);
        rec_t r;
        r = '0; r.chk = 1'b1; r.busy = 1'b1; r.run = !last; r.pc = m_pc;
        return r;
    endfunction

    // Driver and comparator: one record per cycle, regfile/store commits at the edge
    initial begin : cycle_proc
        rec_t        r;
        logic        w_we, s_we, prev_req;
        logic [2:0]  w_a;
        logic [31:0] w_d;
        logic [63:0] s_e;
        logic [34:0] e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rq.size() > 0) r = rq.pop_front();
            else r = '0;
            rst = r.rst; run = r.run;
            imem_ready = r.imem_ready; imem_rdata = r.imem_rdata;
            dmem_ready = r.dmem_ready; dmem_rdata = r.dmem_rdata;
            #1;
            if (r.chk) begin
                chk("busy", 32'(busy), 32'(r.busy));
                chk("pc", pc, r.pc);
                chk("imem_req", 32'(imem_req), 32'(r.imem_req));
                if (r.imem_req) chk("imem_addr", imem_addr, r.imem_addr);
                if (r.dec) begin
                    chk("rf_raddr0", 32'(rf_raddr0), 32'(r.raddr0));
                    chk("rf_raddr1", 32'(rf_raddr1), 32'(r.raddr1));
                end
                chk("rf_we", 32'(rf_we), 32'(r.rf_we));
                if (r.rf_we) begin
                    chk("rf_waddr", 32'(rf_waddr), 32'(r.waddr));
                    chk("rf_wdata", rf_wdata, r.wdata);
                end
                chk("alu_opcode", 32'(alu_opcode), 32'(r.alu_opc));
                chk("alu_ip_0", alu_ip_0, r.ip0);
                chk("alu_ip_1", alu_ip_1, r.ip1);
                chk("dmem_req", 32'(dmem_req), 32'(r.dmem_req));
                chk("dmem_we", 32'(dmem_we), 32'(r.dmem_we));
                if (r.dmem_req) chk("dmem_addr", dmem_addr, r.dmem_addr);
                if (r.dmem_we) chk("dmem_wdata", dmem_wdata, r.dmem_wdata);
`ifdef MULTICYCLE_CTRL_PERF_EN
                chk("cycle_cnt", cycle_cnt, m_cyc);
                chk("retire_cnt", retire_cnt, m_ret);
`else
                chk("cycle_cnt", cycle_cnt, 32'd0);
                chk("retire_cnt", retire_cnt, 32'd0);
`endif
                if (r.zero) begin
                    chk("rst_imem_addr", imem_addr, 32'd0);
                    chk("rst_rf_raddr", 32'({rf_raddr0, rf_raddr1}), 32'd0);
                    chk("rst_rf_wr", 32'(rf_waddr) | rf_wdata, 32'd0);
                    chk("rst_dmem_addr", dmem_addr, 32'd0);
                    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
                end
            end
            if (r.rst) begin
                m_cyc = '0; m_ret = '0;
            end else begin
                if (r.busy)   m_cyc = m_cyc + 32'd1;
                if (r.retire) m_ret = m_ret + 32'd1;
            end
            cyc++;
            if (imem_req && !prev_req) req_rise = cyc;
            prev_req = imem_req;
            if (rf_we) we_cyc = cyc;
            if (dmem_req && dmem_addr == 32'h104) addr_hold++;
            w_we = rf_we; w_a = rf_waddr; w_d = rf_wdata;
            s_we = dmem_req && dmem_we && dmem_ready; s_e = {dmem_addr, dmem_wdata};
            @(posedge clk);
            if (w_we) rf[w_a] = w_d;
            if (s_we) st_log.push_back(s_e);
            while (ini_q.size() > 0) begin
                e = ini_q.pop_front();
                rf[e[34:32]] = e[31:0];
            end
        end
    end

    task automatic set_reg(input logic [2:0] i, input logic [31:0] v);
        m_rf[i] = v;
        ini_q.push_back({i, v});
    endtask

    task automatic push_state(input bit go, input bit zero);
        rec_t r;
        r = '0; r.chk = 1'b1; r.run = go; r.zero = zero; r.pc = m_pc;
        rq.push_back(r);
    endtask

    task automatic do_reset();
        rec_t r;
        r = '0; r.rst = 1'b1;
        rq.push_back(r); rq.push_back(r);
        m_pc = RESET_PC;
        push_state(1'b0, 1'b1);
    endtask

    // Expand one instruction into per-cycle expectations from its architectural effect
    task automatic do_instr(input logic [31:0] ins, input int iw, input int dw, input bit last, input int rst_k);
        rec_t        r;
        logic [2:0]  op, rd, rs1, rs2;
        logic [31:0] imm, a, b, res, npc, addr;
        op = ins[31:29]; rd = ins[28:26]; rs1 = ins[25:23]; rs2 = ins[22:20];
        imm = {{16{ins[15]}}, ins[15:0]};
        a = m_rf[rs1]; b = m_rf[rs2]; npc = m_pc + 32'd4; res = '0;
        for (int k = 0; k <= iw; k++) begin
            r = base(last); r.imem_req = 1'b1; r.imem_addr = m_pc;
            r.imem_ready = (k == iw); r.imem_rdata = (k == iw) ? ins : 32'hFFFF_FFFF;
            rq.push_back(r);
        end
        r = base(last); r.dec = 1'b1; r.raddr0 = rs1; r.raddr1 = rs2;
        rq.push_back(r);
        r = base(last);
        r.alu_opc = (op < 3'd2) ? 3'd4 : op;
        r.ip0 = a; r.ip1 = (op < 3'd2) ? imm : b;
        if (op == 3'd2 || op == 3'd3) begin
            if ((op == 3'd2) ? (a == b) : (a < b)) npc = m_pc + (imm << 2);
            r.retire = 1'b1;
        end
        rq.push_back(r);
        case (op)
            3'd4: res = a + b;
            3'd5: res = a - b;
            3'd6: res = a & b;
            3'd7: res = a | b;
            default: ;
        endcase
        if (op < 3'd2) begin
            addr = a + imm;
            res  = dmem_val(addr);
            for (int k = 0; k <= dw; k++) begin
                r = base(last); r.dmem_req = 1'b1; r.dmem_we = (op == 3'd1);
                r.dmem_addr = addr; r.dmem_wdata = b;
                r.dmem_ready = (k == dw); r.dmem_rdata = (k == dw) ? res : 32'h0BAD_0BAD;
                if (k == rst_k) begin
                    r.rst = 1'b1; r.dmem_ready = 1'b1; r.dmem_req = 1'b0; r.dmem_we = 1'b0;
                    rq.push_back(r);
                    m_pc = RESET_PC;
                    return;
                end
                if (op == 3'd1 && k == dw) r.retire = 1'b1;
                rq.push_back(r);
            end
            if (op == 3'd1) exp_st.push_back({addr, b});
        end
        if (op == 3'd0 || op >= 3'd4) begin
            r = base(last); r.rf_we = (rd != 3'd0); r.waddr = rd; r.wdata = res; r.retire = 1'b1;
            rq.push_back(r);
            if (rd != 3'd0) m_rf[rd] = res;
        end
        m_pc = npc;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rq.size() > 0 || ini_q.size() > 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout: got %0d records left expected 0", rq.size());
        end
        repeat (2) @(negedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_rf[i] = '0;
            rf[i]   = '0;
        end
        m_pc = RESET_PC; m_cyc = '0; m_ret = '0;
        do_reset(); drain();

        set_reg(3'd1, 32'd5); set_reg(3'd2, 32'd7); drain();
        push_state(1'b1, 1'b0);
        do_instr(32'h8CA0_0000, 0, 0, 1'b0, -1);
        do_instr(32'h40A0_FFFE, 0, 0, 1'b1, -1);
        push_state(1'b0, 1'b0); drain();
        chk("lit_add_rf3", rf[3], 32'd12);
        chk("lit_g1_pc", pc, 32'h8);
        chk("lit_g1_model_pc", m_pc, 32'h8);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("lit_cycle_cnt", cycle_cnt, 32'd7);
        chk("lit_retire_cnt", retire_cnt, 32'd2);
`else
        chk("lit_cycle_cnt", cycle_cnt, 32'd0);
        chk("lit_retire_cnt", retire_cnt, 32'd0);
`endif

        push_state(1'b1, 1'b0);
        do_instr(32'hB110_0000, 0, 0, 1'b0, -1);
        do_instr(32'hD4A0_0000, 0, 0, 1'b1, -1);
        push_state(1'b0, 1'b0); drain();
        chk("lit_sub_rf4", rf[4], 32'd2);
        chk("lit_and_rf5", rf[5], 32'd5);
        chk("lit_g2_pc", pc, 32'h10);

        set_reg(3'd1, 32'd9); set_reg(3'd2, 32'd9); drain();
        push_state(1'b1, 1'b0);
        do_instr(32'h40A0_FFFE, 0, 0, 1'b1, -1);
        push_state(1'b0, 1'b0); drain();
        chk("lit_beq_taken_pc", pc, 32'h8);
        chk("lit_beq_model_pc", m_pc, 32'h8);

        set_reg(3'd1, 32'd8); set_reg(3'd2, 32'd3); drain();
        push_state(1'b1, 1'b0);
        do_instr(32'h60A0_0010, 0, 0, 1'b0, -1);
        do_instr(32'hE0A0_0000, 1, 0, 1'b1, -1);
        push_state(1'b0, 1'b0); drain();
        chk("lit_blt_nt_pc", pc, 32'h10);
        chk("lit_rd0_unwritten", rf[0], 32'd0);

        set_reg(3'd6, 32'h100); drain();
        push_state(1'b1, 1'b0);
        do_instr(32'h1F00_0004, 0, 2, 1'b1, -1);
        push_state(1'b0, 1'b0); drain();
        chk("lit_ld_rf7", rf[7], 32'h5A5A_0104);
        chk("lit_ld_latency", 32'(we_cyc - req_rise + 1), 32'd7);
        chk("lit_ld_addr_hold", 32'(addr_hold), 32'd3);
        chk("lit_ld_pc", pc, 32'h14);

        push_state(1'b1, 1'b0);
        do_instr(32'h2310_0008, 0, 0, 1'b0, -1);
        do_instr(32'h6110_0003, 0, 0, 1'b1, -1);
        push_state(1'b0, 1'b0); drain();
        chk("lit_blt_taken_pc", pc, 32'h24);

        push_state(1'b1, 1'b0);
        do_instr(32'h2310_0008, 0, 2, 1'b1, 1);
        push_state(1'b0, 1'b1); drain();
        chk("lit_rst_pc", pc, RESET_PC);
        chk("lit_store_count", 32'(st_log.size()), 32'd1);
        if (st_log.size() > 0) chk("lit_store0_addr", st_log[0][63:32], 32'h108);
        if (st_log.size() > 0) chk("lit_store0_data", st_log[0][31:0], 32'd8);

        push_state(1'b1, 1'b0);
        do_instr(32'h4090_FFFC, 0, 0, 1'b1, -1);
        push_state(1'b0, 1'b0); drain();
        chk("lit_pc_wrap", pc, 32'hFFFF_FFF0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("lit_cycle_after_rst", cycle_cnt, 32'd3);
        chk("lit_retire_after_rst", retire_cnt, 32'd1);
`endif

        chk("store_log_size", 32'(st_log.size()), 32'(exp_st.size()));
        for (int i = 0; i < st_log.size() && i < exp_st.size(); i++) begin
            chk("store_addr", st_log[i][63:32], exp_st[i][63:32]);
            chk("store_data", st_log[i][31:0], exp_st[i][31:0]);
        end
        for (int i = 0; i < 8; i++) chk("regfile_final", rf[i], m_rf[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
